// File: rtl/sync_fifo_ext.sv
// sync_fifo_ext: parametrised single-clock FIFO with selectable
// first-word-fall-through or registered read, a fill-level count,
// programmable almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and a synchronous flush.
`timescale 1ns/1ps

module sync_fifo_ext #(
  parameter int fifo_elements = 8,   // depth, power of 2, >= 2
  parameter int no_bits       = 32,  // data width
  parameter int FWFT          = 0,   // 0: registered read, 1: fall-through
  parameter int AF_LEVEL      = 6,   // almost_full when count >= AF_LEVEL
  parameter int AE_LEVEL      = 2    // almost_empty when count <= AE_LEVEL
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cs,
  input  logic                             wr_en,
  input  logic                             rd_en,
  input  logic                             flush,
  input  logic [no_bits-1:0]               d_in,
  output logic [no_bits-1:0]               d_out,
  output logic                             rd_valid,
  output logic                             empty,
  output logic                             full,
  output logic                             almost_empty,
  output logic                             almost_full,
  output logic [$clog2(fifo_elements):0]   count,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int AW = $clog2(fifo_elements);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] DEPTH  = CW'(fifo_elements);
  localparam logic [CW-1:0] AF_THR = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_THR = CW'(AE_LEVEL);

  // Pointers carry an extra wrap bit above the storage address.
  logic [CW-1:0]      wr_ptr;
  logic [CW-1:0]      rd_ptr;
  logic [CW-1:0]      count_q;
  logic [no_bits-1:0] mem [fifo_elements];

  logic clear;
  logic rd_ok;
  logic wr_ok;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] wr_addr;

  assign rd_addr = rd_ptr[AW-1:0];
  assign wr_addr = wr_ptr[AW-1:0];

  // Status flags are decoded from the registered count only.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH);
  assign almost_empty = (count_q <= AE_THR);
  assign almost_full  = (count_q >= AF_THR);
  assign count        = count_q;

  // Reset clears regardless of chip select; flush only when selected.
  assign clear = reset | (cs & flush);

  // A pop into an empty FIFO is refused; a push into a full FIFO is
  // allowed only when a pop frees a slot in the same cycle.
  assign rd_ok = cs & rd_en & ~empty;
  assign wr_ok = cs & wr_en & (~full | rd_ok);

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking (<=) so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ONE;
      if (rd_ok) rd_ptr <= rd_ptr + ONE;
      if (wr_ok && !rd_ok)      count_q <= count_q + ONE;
      else if (rd_ok && !wr_ok) count_q <= count_q - ONE;
    end
  end

  // Sticky error flags, cleared only by reset or flush.
  always_ff @(posedge clk) begin
    if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (cs && wr_en && !wr_ok) overflow  <= 1'b1;
      if (cs && rd_en && empty)  underflow <= 1'b1;
    end
  end

  // Storage write; a push coinciding with flush or reset is dropped.
  // NOTE: the data array has no reset -- the pointers and count define
  // which words are valid, so clearing it would only cost logic and
  // prevent mapping onto RAM.
  always_ff @(posedge clk) begin
    if (wr_ok && !clear) mem[wr_addr] <= d_in;
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [no_bits-1:0] dout_q;
      logic               rv_q;

      // Registered read: load the head word on an accepted pop.
      always_ff @(posedge clk) begin
        if (clear) begin
          dout_q <= '0;
          rv_q   <= 1'b0;
        end else begin
          rv_q <= rd_ok;
          if (rd_ok) dout_q <= mem[rd_addr];
        end
      end

      assign d_out    = dout_q;
      assign rd_valid = rv_q;
    end else begin : g_fwft_read
      // Fall-through: head word visible while not empty, zero otherwise.
      // NOTE: d_out gets its default before the condition so every path
      // assigns it and no latch is inferred.
      always_comb begin
        d_out = '0;
        if (!empty) d_out = mem[rd_addr];
      end

      assign rd_valid = ~empty;
    end
  endgenerate

  // The occupancy register must always match the pointer distance.
  a_count_matches_ptrs : assert property (
    @(posedge clk) disable iff (reset) count_q == CW'(wr_ptr - rd_ptr)
  );

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Self-checking bench for sync_fifo_ext: one registered-read instance and
// one fall-through instance share the same stimulus and are compared
// against a queue-based reference model, a directed vector table and
// hand-written corner-case sequences.
`timescale 1ns/1ps

module tb_sync_fifo_ext;

  localparam int DEPTH = 8;
  localparam int W     = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic         clk = 1'b0;
  logic         reset, cs, wr_en, rd_en, flush;
  logic [W-1:0] d_in;

  logic [W-1:0]  r_dout, f_dout;
  logic          r_rv, f_rv, r_empty, f_empty, r_full, f_full;
  logic          r_ae, f_ae, r_af, f_af, r_ovf, f_ovf, r_unf, f_unf;
  logic [CW-1:0] r_count, f_count;

  always #5 clk = ~clk;

  sync_fifo_ext #(.fifo_elements(DEPTH), .no_bits(W), .FWFT(0),
                  .AF_LEVEL(AF), .AE_LEVEL(AE)) u_reg (
    .clk(clk), .reset(reset), .cs(cs), .wr_en(wr_en), .rd_en(rd_en),
    .flush(flush), .d_in(d_in), .d_out(r_dout), .rd_valid(r_rv),
    .empty(r_empty), .full(r_full), .almost_empty(r_ae),
    .almost_full(r_af), .count(r_count), .overflow(r_ovf),
    .underflow(r_unf)
  );

  sync_fifo_ext #(.fifo_elements(DEPTH), .no_bits(W), .FWFT(1),
                  .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
    .clk(clk), .reset(reset), .cs(cs), .wr_en(wr_en), .rd_en(rd_en),
    .flush(flush), .d_in(d_in), .d_out(f_dout), .rd_valid(f_rv),
    .empty(f_empty), .full(f_full), .almost_empty(f_ae),
    .almost_full(f_af), .count(f_count), .overflow(f_ovf),
    .underflow(f_unf)
  );

  // Directed vector: inputs plus expected registered-read outputs.
  typedef struct {
    bit           rst, c, w, r, f;
    logic [W-1:0] din;
    int           exp_count;
    bit           exp_rv;
    logic [W-1:0] exp_dout;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  // Reference model: contents as a queue, plus the observable registers.
  logic [W-1:0] mq[$];
  bit           m_ovf, m_unf, m_rv;
  logic [W-1:0] m_dout;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Apply one clock edge to the model from its rules.
  task automatic model_edge(bit rst, bit c, bit w, bit r, bit f, logic [W-1:0] din);
    bit pop_ok, push_ok;
    if (rst || (c && f)) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_rv = 0; m_dout = '0;
    end else if (!c) begin
      m_rv = 0;
    end else begin
      pop_ok  = r && (mq.size() > 0);
      push_ok = w && ((mq.size() < DEPTH) || pop_ok);
      if (r && mq.size() == 0) m_unf = 1;
      if (w && !push_ok)       m_ovf = 1;
      m_rv = pop_ok;
      if (pop_ok)  m_dout = mq.pop_front();
      if (push_ok) mq.push_back(din);
    end
  endtask

  task automatic check_model(string tag);
    int           n;
    logic [W-1:0] head;
    n    = mq.size();
    head = (n > 0) ? mq[0] : '0;
    check({tag, ".r_count"}, 32'(r_count), 32'(n));
    check({tag, ".f_count"}, 32'(f_count), 32'(n));
    check({tag, ".r_empty"}, 32'(r_empty), 32'(n == 0));
    check({tag, ".f_empty"}, 32'(f_empty), 32'(n == 0));
    check({tag, ".r_full"},  32'(r_full),  32'(n == DEPTH));
    check({tag, ".f_full"},  32'(f_full),  32'(n == DEPTH));
    check({tag, ".r_ae"},    32'(r_ae),    32'(n <= AE));
    check({tag, ".f_ae"},    32'(f_ae),    32'(n <= AE));
    check({tag, ".r_af"},    32'(r_af),    32'(n >= AF));
    check({tag, ".f_af"},    32'(f_af),    32'(n >= AF));
    check({tag, ".r_ovf"},   32'(r_ovf),   32'(m_ovf));
    check({tag, ".f_ovf"},   32'(f_ovf),   32'(m_ovf));
    check({tag, ".r_unf"},   32'(r_unf),   32'(m_unf));
    check({tag, ".f_unf"},   32'(f_unf),   32'(m_unf));
    check({tag, ".r_rv"},    32'(r_rv),    32'(m_rv));
    check({tag, ".r_dout"},  r_dout,       m_dout);
    check({tag, ".f_rv"},    32'(f_rv),    32'(n > 0));
    check({tag, ".f_dout"},  f_dout,       head);
  endtask

  // Drive one cycle of inputs, advance the model, check 1 ns after the edge.
  task automatic step(bit rst, bit c, bit w, bit r, bit f, logic [W-1:0] din, string tag);
    reset = rst; cs = c; wr_en = w; rd_en = r; flush = f; d_in = din;
    @(posedge clk);
    model_edge(rst, c, w, r, f, din);
    #1;
    check_model(tag);
  endtask

  task automatic push(logic [W-1:0] din, string tag);
    step(0, 1, 1, 0, 0, din, tag);
  endtask

  task automatic pop(string tag);
    step(0, 1, 0, 1, 0, '0, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Directed table: reset, write 1,2,4..128, read all back, idle.
    vecs[0] = '{rst:1, c:0, w:0, r:0, f:0, din:'0, exp_count:0, exp_rv:0, exp_dout:'0};
    for (int i = 0; i < 8; i++)
      vecs[1 + i] = '{rst:0, c:1, w:1, r:0, f:0, din:(32'd1 << i),
                      exp_count:i + 1, exp_rv:0, exp_dout:'0};
    for (int i = 0; i < 8; i++)
      vecs[9 + i] = '{rst:0, c:1, w:0, r:1, f:0, din:'0,
                      exp_count:7 - i, exp_rv:1, exp_dout:(32'd1 << i)};
    vecs[17] = '{rst:0, c:1, w:0, r:0, f:0, din:'0, exp_count:0, exp_rv:0, exp_dout:32'h80};

    reset = 1; cs = 0; wr_en = 0; rd_en = 0; flush = 0; d_in = '0;

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst, vecs[i].c, vecs[i].w, vecs[i].r, vecs[i].f, vecs[i].din, "vec");
      check("vec.count",  32'(r_count), 32'(vecs[i].exp_count));
      check("vec.rv",     32'(r_rv),    32'(vecs[i].exp_rv));
      check("vec.dout",   r_dout,       vecs[i].exp_dout);
    end
    check("vec.empty_end", 32'(r_empty), 32'd1);

    // Fill to full; almost_full first appears at count 6.
    for (int i = 0; i < 8; i++) begin
      push(32'hA0 + 32'(i), "fill");
      if (i == 4) check("af_below_level", 32'(r_af), 32'd0);
      if (i == 5) check("af_at_level",    32'(r_af), 32'd1);
    end
    check("full_set",  32'(r_full),  32'd1);
    check("full_cnt",  32'(r_count), 32'd8);
    push(32'hDEAD_BEEF, "overflow");
    check("ovf_set",   32'(r_ovf),   32'd1);
    check("ovf_cnt",   32'(r_count), 32'd8);

    // Full FIFO: simultaneous push and pop.
    step(0, 1, 1, 1, 0, 32'hFF, "full_rw");
    check("full_rw_dout", r_dout, 32'hA0);
    check("full_rw_cnt",  32'(r_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      pop("drain");
      check("drain_dout", r_dout, (i < 7) ? 32'hA1 + 32'(i) : 32'hFF);
    end

    // Underflow on empty, then flush clears both sticky flags.
    pop("underflow");
    check("unf_set",  32'(r_unf), 32'd1);
    check("unf_dout", r_dout,     32'hFF);
    check("unf_rv",   32'(r_rv),  32'd0);
    step(0, 1, 1, 1, 1, 32'h1234, "flush");
    check("flush_unf",  32'(r_unf),   32'd0);
    check("flush_ovf",  32'(r_ovf),   32'd0);
    check("flush_cnt",  32'(r_count), 32'd0);
    check("flush_dout", r_dout,       32'd0);

    // Fall-through visibility after a write into an empty FIFO.
    push(32'h55, "fwft_push");
    check("fwft_dout", f_dout,      32'h55);
    check("fwft_rv",   32'(f_rv),   32'd1);
    pop("fwft_pop");
    check("fwft_empty",   32'(f_empty), 32'd1);
    check("fwft_dout_0",  f_dout,       32'd0);

    // Chip select low blocks push, pop and flush.
    push(32'h99, "cs_pre");
    step(0, 0, 1, 1, 1, 32'h42, "cs_low");
    check("cs_low_cnt", 32'(r_count), 32'd1);
    pop("cs_post");

    // Reset mid-stream abandons contents; next push/pop sees fresh data.
    for (int i = 0; i < 5; i++) push(32'h10 + 32'(i), "pre_reset");
    step(1, 1, 1, 0, 0, 32'h66, "mid_reset");
    check("rst_cnt",   32'(r_count), 32'd0);
    check("rst_empty", 32'(r_empty), 32'd1);
    check("rst_ae",    32'(r_ae),    32'd1);
    check("rst_af",    32'(r_af),    32'd0);
    check("rst_rdout", r_dout,       32'd0);
    check("rst_fdout", f_dout,       32'd0);
    push(32'h77, "post_reset_push");
    check("post_rst_fdout", f_dout, 32'h77);
    pop("post_reset_pop");
    check("post_rst_rdout", r_dout, 32'h77);

    // Randomised traffic; write bias alternates to visit full and empty.
    for (int i = 0; i < 2000; i++) begin
      int wbias;
      wbias = ((i / 100) % 2 == 0) ? 8 : 3;
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) < wbias),
           ($urandom_range(0, 9) < (11 - wbias)),
           ($urandom_range(0, 79) == 0),
           $urandom, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
Parametrised synchronous FIFO, successor to the team's basic 8x32 sync FIFO. Adds:
- selectable first-word-fall-through (FWFT) or registered-read mode
- fill-level count output
- programmable almost-full and almost-empty flags
- sticky overflow and underflow error flags
- synchronous flush

It sits between any two same-clock producer/consumer blocks, e.g. a data-path stage and a bus interface.

Parameters:
- fifo_elements, 8: depth in words; must be a power of 2 and at least 2.
- no_bits, 32: data width in bits; at least 1.
- FWFT, 0: 0 = registered read (data appears one cycle after the pop); 1 = head word visible on d_out whenever the FIFO is not empty.
- AF_LEVEL, 6: almost_full asserts when count >= AF_LEVEL; range 1..fifo_elements.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL; range 0..fifo_elements-1.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- cs  input  1  chip select; gates wr_en, rd_en and flush.
- wr_en  input  1  push request.
- rd_en  input  1  pop request.
- flush  input  1  synchronous clear of FIFO contents.
- d_in  input  no_bits  write data.
- d_out  output  no_bits  read data.
- rd_valid  output  1  FWFT=0: one-cycle pulse, d_out holds freshly popped data. FWFT=1: equals !empty.
- empty  output  1  count == 0.
- full  output  1  count == fifo_elements.
- almost_empty  output  1  count <= AE_LEVEL.
- almost_full  output  1  count >= AF_LEVEL.
- count  output  $clog2(fifo_elements)+1  number of stored words.
- overflow  output  1  sticky: a push was rejected.
- underflow  output  1  sticky: a pop was rejected.

Behaviour:
- Pointers: write and read pointers are $clog2(fifo_elements)+1 bits wide. The MSB is a wrap bit; the low bits address storage. Pointers wrap naturally modulo 2*fifo_elements.
- count is a register, not derived from the pointers. All status flags are combinational from the registered count.
- Pop accepted: rd_ok = cs & rd_en & !empty.
- Push accepted: wr_ok = cs & wr_en & (!full | rd_ok).
  - Push while full is accepted only if a pop is accepted in the same cycle.
  - Push while empty with a simultaneous pop: the pop is rejected and the push is accepted.
- count update:
  - wr_ok and not rd_ok: count + 1.
  - rd_ok and not wr_ok: count - 1.
  - both or neither: count unchanged.
- Memory: written at the write-pointer address on wr_ok. Memory is not reset.
- FWFT=0 read path:
  - d_out is registered: on rd_ok it loads the word at the read-pointer address. Otherwise it holds its value.
  - rd_valid is high for exactly the cycle after rd_ok.
  - Latency: pop edge to data valid is 1 cycle.
- FWFT=1 read path:
  - d_out is combinational: the head word when !empty, all zeros when empty.
  - rd_valid = !empty. The rd_ok edge advances to the next word.
  - A word written into an empty FIFO appears on d_out the cycle after its write edge.
- overflow: set when cs & wr_en & !wr_ok.
- underflow: set when cs & rd_en & empty.
- Both sticky flags are cleared only by reset or flush.
- flush (when cs=1):
  - Next edge: both pointers, count, rd_valid, overflow and underflow go to 0. d_out goes to 0 in FWFT=0.
  - Any wr_en or rd_en in that cycle is ignored.
- reset: same clearing effect as flush, independent of cs. Highest priority.
- Reset values:
  - d_out = 0, rd_valid = 0, count = 0, overflow = 0, underflow = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
- Reset mid-operation: all stored words are abandoned. The first push after reset lands at address 0.
- cs=0: no push, no pop, no flag change, no flush; all state holds.

Test Plan (fifo_elements=8, no_bits=32):
1. Reset, then in FWFT=0 write 1,2,4..128 and read each back -> rd_valid pulses 1 cycle after each pop with d_out 1,2,4..128 in order; count returns to 0 and empty=1.
2. Push 8 words 0xA0..0xA7 -> full=1 and count=8; almost_full first asserts at count=6. A 9th push gives overflow=1, count stays 8, and the data is not stored.
3. Full FIFO, simultaneous push 0xFF and pop -> pop returns 0xA0, count stays 8, and 0xFF is read out last.
4. Empty FIFO with rd_en=1 -> underflow=1, d_out unchanged, rd_valid=0. Then flush -> underflow=0.
5. FWFT=1: push 0x55 -> d_out=0x55 and rd_valid=1 the cycle after the write edge. Pop -> empty=1 and d_out=0.
6. Push 5 words, then assert reset mid-stream -> all outputs return to reset values. The next push 0x77 followed by a pop returns 0x77, showing no stale data.
